// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-bit slice reused WIDTH/DIGIT times; done pulses WIDTH/DIGIT+1 cycles after start is accepted.
// start is accepted only while ready; define SERIAL_ADDER_SUB_EN to add a sub port (a - b, cout=1 means no borrow).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [DIGIT:0]   digit;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and inject a carry of one.
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign digit = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_in;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = digit[DIGIT];
        // Partial sums enter at the top so the low digit ends up at bit 0.
        res_d   = (res_q >> DIGIT) | (WIDTH'(digit[DIGIT-1:0]) << (WIDTH - DIGIT));
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = digit[DIGIT];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder that adds two WIDTH-bit operands plus a carry-in.
- Processes DIGIT bits per clock, low digit first, and keeps the carry in a flip-flop between digits.
- Trades latency for area: only one DIGIT-bit adder slice, reused WIDTH/DIGIT times.
- Used wherever a wide add is needed without a wide combinational carry chain. Start/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥1 and an integer multiple of DIGIT.
- DIGIT, 1, bits processed per clock cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- ready  output  1  high when idle and able to accept start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out of the MSB.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- N = WIDTH/DIGIT. Three-state FSM: IDLE, RUN, DONE. Digit counter width is clog2(N), minimum 1.
- Reset (rst=1 at an edge, any state including RUN) forces the following:
  - state=IDLE, counter=0, carry=0, internal shift registers=0.
  - sum=0, cout=0, done=0, busy=0, ready=1.
  - An in-flight operation is discarded and no done is issued.
- IDLE:
  - ready=1.
  - If start=1, the edge latches a, b and cin into operand shift registers and the carry flip-flop, clears the counter, and goes to RUN.
  - Otherwise stays in IDLE.
- RUN:
  - busy=1, ready=0.
  - Each edge adds the low DIGIT bits of A and B plus carry to give a DIGIT-bit partial sum and a new carry.
  - The partial sum shifts into the top of the result shift register; A and B shift right by DIGIT; the counter increments.
  - On the edge where counter = N-1, the final digit is processed. The same edge loads sum from the result register and cout from the final carry, then moves to DONE.
- DONE:
  - done=1 for exactly this one cycle; busy=0, ready=0.
  - The next edge goes to IDLE unconditionally.
  - start during DONE is ignored and not queued.
- Latency: start=1 with ready=1 in cycle k gives RUN in cycles k+1..k+N and done=1 in cycle k+N+1. Throughput is one operation per N+2 cycles.
- sum/cout hold the previous result throughout RUN and DONE→IDLE. They change only on the completing edge or on reset.
- start, a, b and cin are don't-care outside the accepting edge. Changes to them during RUN do not affect the result.
- Arithmetic is modulo 2^WIDTH with carry-out, i.e. {cout,sum} = a + b + cin, exact for all inputs.
- DIGIT=WIDTH (N=1) is legal: one RUN cycle, done in cycle k+2.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- When defined:
  - Extra input port sub (1 bit), sampled with the operands.
  - sub=1: B is latched bit-inverted and the initial carry is forced to 1, so sum = a - b mod 2^WIDTH; cin is ignored.
  - cout=1 means no borrow (a ≥ b unsigned).
  - sub=0: plain add.
- When undefined: no sub port, add only, and no inverter logic is generated.

Test Plan:
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0, start in cycle k → done=1 only in cycle k+9; sum=0x00, cout=1. busy=1 in cycles k+1..k+8; ready=0 in cycles k+1..k+9.
- WIDTH=8, DIGIT=4: a=0x3C, b=0x45, cin=1 → done in cycle k+3; sum=0x82, cout=0. Change a/b to 0x00 during RUN → result unchanged.
- WIDTH=8, DIGIT=1:
  - First add 0x10+0x20 gives sum=0x30.
  - Then start 0x80+0x80: sum stays 0x30 through RUN, then becomes 0x00 with cout=1 at done.
  - start held high continuously accepts exactly one operation per 10 cycles.
- Reset mid-operation: assert rst in the 4th RUN cycle → next cycle ready=1, busy=0, sum=0, cout=0. No done pulse follows; a new start completes normally.
- DIGIT=WIDTH=16: a=0xFFFF, b=0xFFFF, cin=1 → done in cycle k+2; sum=0xFFFF, cout=1.
- With SERIAL_ADDER_SUB_EN, WIDTH=8: a=0x05, b=0x07, sub=1, cin=0 → sum=0xFE, cout=0. Then a=0x07, b=0x05, sub=1, cin=1 → sum=0x02, cout=1.
